// File: rtl/stage_progress_ctrl.sv
// Stage/level tracker for the memory game: counts hits, advances stages, flags done/fail.
// Optional idle timeout is enabled by defining STAGE_TIMEOUT_EN.
module stage_progress_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int LVL_W       = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  hit,
  input  logic                  miss,
  output logic [NUM_STAGES-1:0] stage_therm,
  output logic [LVL_W-1:0]      level,
  output logic [LVL_W-1:0]      hit_cnt,
  output logic                  clear,
  output logic                  all_clear,
  output logic                  fail
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [LVL_W-1:0] LAST = LVL_W'(NUM_STAGES);

  logic [1:0]       state;
  logic [LVL_W-1:0] nxt_hits;
  logic             play;
  logic             timeout;

  assign play     = (state == S_PLAY);
  assign nxt_hits = hit_cnt + 1'b1;

`ifdef STAGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] idle_cnt;

  // Stage advance is always caused by a hit, so hit covers it here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (start || !play || hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = play && !hit &&
                   (idle_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      level     <= '0;
      hit_cnt   <= '0;
      clear     <= 1'b0;
      all_clear <= 1'b0;
      fail      <= 1'b0;
    end else begin
      clear <= 1'b0;
      if (start) begin
        state     <= S_PLAY;
        level     <= LVL_W'(1);
        hit_cnt   <= '0;
        all_clear <= 1'b0;
        fail      <= 1'b0;
      end else if (play) begin
        if (miss || timeout) begin
          state <= S_FAIL;
          fail  <= 1'b1;
        end else if (hit) begin
          if (nxt_hits != level) begin
            hit_cnt <= nxt_hits;
          end else if (level != LAST) begin
            clear   <= 1'b1;
            level   <= level + 1'b1;
            hit_cnt <= '0;
          end else begin
            state     <= S_DONE;
            all_clear <= 1'b1;
            hit_cnt   <= nxt_hits;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_therm
    assign stage_therm[i] = (LVL_W'(i) < level);
  end

endmodule
